pe_resp_checker: RTL
====================

# pe_resp_checker

Synthesizable response checker: the checking end of the PE stimulus/response flow. A producer pushes expected results into an internal FIFO, the PE under test delivers actual results on a second stream, and the block compares them in order. It counts checks and mismatches, captures the first mismatch, and reports pass/fail once a programmed number of results has been checked. It sits beside a PE instance in hardware self-test builds, in place of the bench-side scoreboard.

## Interface
Parameters:
- DATA_W, 16, width of expected and actual result words
- DEPTH, 8, expected-value FIFO depth; power of two, ≥ 2
- CNT_W, 16, width of all counters and the index field

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle pulse that starts a check run
- num_i  in  CNT_W  number of results to check; latched on start_i
- exp_valid_i  in  1  expected word valid
- exp_data_i  in  DATA_W  expected word
- exp_ready_o  out  1  FIFO accepts the expected word
- res_valid_i  in  1  actual result valid
- res_data_i  in  DATA_W  actual result from the PE
- res_ready_o  out  1  checker consumes the result
- busy_o  out  1  run in progress
- done_o  out  1  run complete; held high until the next start_i
- pass_o  out  1  done_o and err_cnt_o == 0
- chk_cnt_o  out  CNT_W  results compared so far
- err_cnt_o  out  CNT_W  mismatches so far; saturates at all-ones
- first_err_idx_o  out  CNT_W  chk_cnt value at the first mismatch
- first_err_got_o  out  DATA_W  actual word at the first mismatch
- first_err_exp_o  out  DATA_W  expected word at the first mismatch

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start_i with num_i ≠ 0.
- IDLE → DONE on start_i with num_i == 0. This is an empty run and passes.
- RUN → DONE on the compare where chk_cnt_o + 1 == latched num.
- DONE → RUN or DONE on start_i, applying the same num_i rule as IDLE.
- start_i is ignored in RUN.
- Every accepted start_i clears the following: the FIFO, chk_cnt_o, err_cnt_o, the first-error fields, and the first-error flag.
- Expected side:
  - exp_ready_o = (state == RUN) && !full.
  - A push occurs when exp_valid_i && exp_ready_o.
  - In IDLE and DONE, pushes are never accepted.
- Result side:
  - res_ready_o = (state == RUN) && !empty.
  - Compare happens when res_valid_i && res_ready_o: res_data_i is checked against the FIFO head, the head is popped, and chk_cnt_o increments.
- Comparison is bitwise equality over DATA_W.
- On a mismatch, err_cnt_o increments, saturating at 2^CNT_W − 1.
- On the first mismatch of a run, first_err_idx_o, first_err_got_o and first_err_exp_o are captured with the pre-increment chk_cnt_o, and the first-error flag is set. Later mismatches do not overwrite them.
- Push and pop may occur in the same cycle whenever both are permitted. Occupancy is unchanged in that case.
  - When full, a push is refused even if a pop occurs that cycle (no bypass).
  - When empty, res_ready_o = 0 even if a push occurs that cycle (no bypass).
- FIFO implementation: circular buffer with log2(DEPTH)+1-bit read/write pointers. Pointers wrap modulo DEPTH; full/empty are decoded from the MSB difference.
- Expected words left in the FIFO at DONE are retained but unused. The next start_i discards them.
- busy_o = (state == RUN). done_o = (state == DONE).

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE, FIFO empty.
  - exp_ready_o = res_ready_o = busy_o = done_o = pass_o = 0.
  - All counters and first-error fields = 0.
- Reset asserted mid-run aborts the run at once, with all state as above.
- start_i sampled at edge k: busy_o (or done_o, for num = 0) is high from cycle k+1. exp_ready_o can go high in cycle k+1.
- A push at edge k makes the word available for compare at edge k+1. res_ready_o is high in cycle k+1. Minimum expected-to-compare latency: 1 cycle.
- A compare at edge k updates chk_cnt_o, err_cnt_o and the first-error fields, visible in cycle k+1.
- Final compare at edge k: done_o and pass_o are valid in cycle k+1; busy_o and both readies are low in cycle k+1.
- Throughput: one push and one compare per cycle sustained.
- All outputs are registered or decoded from state and pointers only. There are no combinational paths from valid inputs to ready outputs.

## Test plan
- All-match run: reset, start_i with num_i=4. Push 0x0001, 0x0002, 0x0003, 0x0004; return the same four as results → done_o=1, pass_o=1, chk_cnt_o=4, err_cnt_o=0 one cycle after the 4th compare.
- Single mismatch: num_i=3, expected 0x00AA, 0x00BB, 0x00CC, results 0x00AA, 0x00BD, 0x00CC → err_cnt_o=1, first_err_idx_o=1, first_err_got_o=0x00BD, first_err_exp_o=0x00BB, pass_o=0.
- FIFO boundaries:
  - DEPTH=8, hold res_valid_i=0 and push 9 words → exp_ready_o drops after the 8th; the 9th is held.
  - Then assert res_valid_i → the 9th is accepted the cycle after the first pop.
  - Results offered while the FIFO is empty see res_ready_o=0.
- Simultaneous push/pop with pointer wrap: num_i=20, exp_valid_i and res_valid_i held high with matching incrementing data → one compare per cycle after the first push, pointers wrap twice, pass_o=1, chk_cnt_o=20.
- Edge controls:
  - start_i with num_i=0 → done_o=1, pass_o=1 next cycle.
  - start_i during RUN → ignored.
  - rst_i asserted after 2 of 5 compares → all outputs zero immediately, state IDLE.
  - New start_i after reset → counters begin from 0.

Source files
------------

// File: rtl/pe_resp_checker.sv
// Response checker: compares a stream of actual PE results against expected words
// queued in an internal FIFO, counting checks/mismatches and capturing the first error.
module pe_resp_checker #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  num_i,
    input  logic              exp_valid_i,
    input  logic [DATA_W-1:0] exp_data_i,
    output logic              exp_ready_o,
    input  logic              res_valid_i,
    input  logic [DATA_W-1:0] res_data_i,
    output logic              res_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  chk_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [CNT_W-1:0]  first_err_idx_o,
    output logic [DATA_W-1:0] first_err_got_o,
    output logic [DATA_W-1:0] first_err_exp_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t              r_state, w_state_d;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [AW:0]         r_wptr, r_rptr;
    logic [CNT_W-1:0]    r_num, r_chk_cnt, r_err_cnt, r_first_idx;
    logic [DATA_W-1:0]   r_first_got, r_first_exp;
    logic                r_first_seen;

    logic                w_full, w_empty, w_start, w_push, w_pop, w_mismatch, w_last;
    logic [DATA_W-1:0]   w_head;

    // Same index bits with differing MSBs means the writer is a full lap ahead.
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_head   = r_mem[r_rptr[AW-1:0]];

    assign exp_ready_o = (r_state == StRun) && !w_full;
    assign res_ready_o = (r_state == StRun) && !w_empty;
    assign busy_o      = (r_state == StRun);
    assign done_o      = (r_state == StDone);
    assign pass_o      = (r_state == StDone) && (r_err_cnt == '0);

    assign w_start    = start_i && (r_state != StRun);
    assign w_push     = exp_valid_i && exp_ready_o;
    assign w_pop      = res_valid_i && res_ready_o;
    assign w_mismatch = w_pop && (res_data_i != w_head);
    assign w_last     = (r_chk_cnt + CNT_W'(1)) == r_num;

    assign chk_cnt_o       = r_chk_cnt;
    assign err_cnt_o       = r_err_cnt;
    assign first_err_idx_o = r_first_idx;
    assign first_err_got_o = r_first_got;
    assign first_err_exp_o = r_first_exp;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StDone: if (start_i) w_state_d = (num_i != '0) ? StRun : StDone;
            StRun:          if (w_pop && w_last) w_state_d = StDone;
            default:        w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_num        <= '0;
            r_chk_cnt    <= '0;
            r_err_cnt    <= '0;
            r_first_idx  <= '0;
            r_first_got  <= '0;
            r_first_exp  <= '0;
            r_first_seen <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_start) begin
                r_wptr       <= '0;
                r_rptr       <= '0;
                r_num        <= num_i;
                r_chk_cnt    <= '0;
                r_err_cnt    <= '0;
                r_first_idx  <= '0;
                r_first_got  <= '0;
                r_first_exp  <= '0;
                r_first_seen <= 1'b0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop) begin
                    r_rptr    <= r_rptr + 1'b1;
                    r_chk_cnt <= r_chk_cnt + CNT_W'(1);
                end
                if (w_mismatch) begin
                    if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
                    if (!r_first_seen) begin
                        r_first_seen <= 1'b1;
                        r_first_idx  <= r_chk_cnt;
                        r_first_got  <= res_data_i;
                        r_first_exp  <= w_head;
                    end
                end
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= exp_data_i;
    end

endmodule
